// File: rtl/spk_pkg.sv
// Shared constants and types for the spike word serializer slice.
// Latency: none (declarations only).
// Backpressure: not applicable.
package spk_pkg;

    localparam logic [7:0] SPK_HDR_MAGIC = 8'hA5;
    localparam int         SPK_BEAT_W    = 128;
    localparam int         SPK_WORD_W    = 32;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_CAPT = 2'd1,
        WR_PAD  = 2'd2
    } wr_state_t;

    typedef enum logic {
        RD_HDR  = 1'b0,
        RD_DATA = 1'b1
    } rd_state_t;

    typedef struct packed {
        logic [7:0]  magic;
        logic [7:0]  len;
        logic [15:0] seq;
    } hdr_t;

    // Builds the record header word: magic, record length in beats, sequence number.
    function automatic logic [SPK_WORD_W-1:0] spk_hdr_word(input logic [7:0]  len,
                                                           input logic [15:0] seq);
        hdr_t h;
        h.magic = SPK_HDR_MAGIC;
        h.len   = len;
        h.seq   = seq;
        return h;
    endfunction

endpackage

// File: rtl/spk_beat_fifo.sv
// Synchronous 128-bit beat FIFO with registered occupancy and a fall-through head.
// Latency: a beat pushed at edge t is at the head (and counted) from t+1.
// Backpressure: none internally; the writer must only push when space is known to exist.
module spk_beat_fifo
    import spk_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [SPK_BEAT_W-1:0]   push_dat,
    input  logic                    pop,
    output logic [SPK_BEAT_W-1:0]   pop_dat,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);

    logic [SPK_BEAT_W-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;

    // Storage array; no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); push+pop leaves count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign pop_dat = mem[rd_ptr];

endmodule

// File: rtl/spk_word_serializer.sv
// Buffers whole spikes from the never-stalling beat stream and re-emits them as header+word records.
// Latency: header valid 2 cycles after the first beat of a spike when the reader is idle.
// Backpressure: out_TREADY stalls the reader only; spikes that do not fit in the FIFO are dropped.
module spk_word_serializer
    import spk_pkg::*;
#(
    parameter int SPK_LENTH  = 19,  // beats per record
    parameter int FIFO_DEPTH = 64   // power of two, >= SPK_LENTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spk_stream_TVALID,
    input  logic [SPK_BEAT_W-1:0] spk_stream_TDATA,
    input  logic                  spk_stream_pulse,
    output logic                  out_TVALID,
    input  logic                  out_TREADY,
    output logic [SPK_WORD_W-1:0] out_TDATA,
    output logic                  out_TLAST,
    output logic [31:0]           spk_count,
    output logic [31:0]           drop_count,
    output logic [31:0]           trunc_count
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int LW = $clog2(SPK_LENTH + 1);

    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] LEN_C     = CW'(SPK_LENTH);
    localparam logic [LW-1:0] LAST_BEAT = LW'(SPK_LENTH - 1);
    localparam logic [7:0]    HDR_LEN   = 8'(SPK_LENTH);

    wr_state_t             wr_state;
    logic [LW-1:0]         wcnt;
    rd_state_t             rd_state;
    logic [LW-1:0]         bcnt;
    logic [1:0]            wsel;
    logic [15:0]           seq;

    logic                  fifo_push;
    logic [SPK_BEAT_W-1:0] fifo_push_dat;
    logic                  fifo_pop;
    logic [SPK_BEAT_W-1:0] fifo_head;
    logic [CW-1:0]         fifo_count;

    logic                  fits;
    logic                  hs;
    logic                  next_avail;

    spk_beat_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_dat (fifo_push_dat),
        .pop      (fifo_pop),
        .pop_dat  (fifo_head),
        .count    (fifo_count)
    );

    // Admission uses occupancy before this cycle's pop, so it is conservative by at most one beat.
    assign fits       = (DEPTH_C - fifo_count) >= LEN_C;
    assign hs         = out_TVALID && out_TREADY;
    assign fifo_pop   = hs && (rd_state == RD_DATA) && (wsel == 2'd3);
    // A beat behind the one being popped lets the next word follow without a bubble.
    assign next_avail = fifo_count > CW'(1);

    // FIFO write side: admitted first beat, captured beats, or zero padding.
    always_comb begin
        fifo_push     = 1'b0;
        fifo_push_dat = spk_stream_TDATA;
        case (wr_state)
            WR_IDLE: fifo_push = spk_stream_pulse && fits;
            WR_CAPT: fifo_push = spk_stream_TVALID;
            WR_PAD: begin
                fifo_push     = 1'b1;
                fifo_push_dat = '0;
            end
            default: fifo_push = 1'b0;
        endcase
    end

    // Write FSM: admit whole spikes only, pad short ones, count admitted/dropped/padded spikes.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state    <= WR_IDLE;
            wcnt        <= '0;
            spk_count   <= '0;
            drop_count  <= '0;
            trunc_count <= '0;
        end else begin
            case (wr_state)
                WR_IDLE: begin
                    if (spk_stream_pulse) begin
                        if (fits) begin
                            spk_count <= spk_count + 32'd1;
                            wcnt      <= LW'(1);
                            if (SPK_LENTH > 1) begin
                                wr_state <= WR_CAPT;
                            end
                        end else begin
                            drop_count <= drop_count + 32'd1;
                        end
                    end
                end
                WR_CAPT: begin
                    if (spk_stream_TVALID) begin
                        wcnt <= wcnt + 1'b1;
                        if (wcnt == LAST_BEAT) begin
                            wr_state <= WR_IDLE;
                        end
                    end else begin
                        trunc_count <= trunc_count + 32'd1;
                        wr_state    <= WR_PAD;
                    end
                end
                WR_PAD: begin
                    wcnt <= wcnt + 1'b1;
                    if (wcnt == LAST_BEAT) begin
                        wr_state <= WR_IDLE;
                    end
                    if (spk_stream_pulse) begin
                        drop_count <= drop_count + 32'd1;
                    end
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

    // Read FSM: header, then four words per beat; pop after word 3, close the record on the last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state   <= RD_HDR;
            out_TVALID <= 1'b0;
            wsel       <= '0;
            bcnt       <= '0;
            seq        <= '0;
        end else begin
            case (rd_state)
                RD_HDR: begin
                    if (!out_TVALID) begin
                        out_TVALID <= (fifo_count != '0);
                    end else if (out_TREADY) begin
                        // Head beat is still in the FIFO, so the first data word follows directly.
                        rd_state <= RD_DATA;
                        wsel     <= '0;
                        bcnt     <= '0;
                    end
                end
                RD_DATA: begin
                    if (!out_TVALID) begin
                        out_TVALID <= (fifo_count != '0);
                    end else if (out_TREADY) begin
                        wsel <= wsel + 2'd1;
                        if (wsel == 2'd3) begin
                            out_TVALID <= next_avail;
                            if (bcnt == LAST_BEAT) begin
                                rd_state <= RD_HDR;
                                bcnt     <= '0;
                                seq      <= seq + 16'd1;
                            end else begin
                                bcnt <= bcnt + 1'b1;
                            end
                        end
                    end
                end
                default: rd_state <= RD_HDR;
            endcase
        end
    end

    // Word mux: the FIFO head only moves on the pop at handshake, so data holds while stalled.
    always_comb begin
        out_TDATA = '0;
        out_TLAST = 1'b0;
        if (out_TVALID) begin
            if (rd_state == RD_HDR) begin
                out_TDATA = spk_hdr_word(HDR_LEN, seq);
            end else begin
                case (wsel)
                    2'd0:    out_TDATA = fifo_head[127:96];
                    2'd1:    out_TDATA = fifo_head[95:64];
                    2'd2:    out_TDATA = fifo_head[63:32];
                    default: out_TDATA = fifo_head[31:0];
                endcase
                out_TLAST = (wsel == 2'd3) && (bcnt == LAST_BEAT);
            end
        end
    end

endmodule

// File: tb/tb_spk_word_serializer.sv
// Bench for spk_word_serializer: vector table, hand-written corner sequences, randomized spikes.
// Expected words come from a record-level model: header, then LEN beats (missing beats zero), 4 words each.
// A negedge monitor collects handshaken words and checks hold-while-stalled.
module tb_spk_word_serializer;
    localparam int LEN   = 19;
    localparam int DEPTH = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         spk_stream_TVALID;
    logic [127:0] spk_stream_TDATA;
    logic         spk_stream_pulse;
    logic         out_TVALID;
    logic         out_TREADY = 1'b0;
    logic [31:0]  out_TDATA;
    logic         out_TLAST;
    logic [31:0]  spk_count;
    logic [31:0]  drop_count;
    logic [31:0]  trunc_count;

    spk_word_serializer #(
        .SPK_LENTH  (LEN),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .spk_stream_TVALID (spk_stream_TVALID),
        .spk_stream_TDATA  (spk_stream_TDATA),
        .spk_stream_pulse  (spk_stream_pulse),
        .out_TVALID        (out_TVALID),
        .out_TREADY        (out_TREADY),
        .out_TDATA         (out_TDATA),
        .out_TLAST         (out_TLAST),
        .spk_count         (spk_count),
        .drop_count        (drop_count),
        .trunc_count       (trunc_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n_beats;   // beats driven for the spike
        int rmode;     // 1: ready held high, 2: random ready
        int pattern;   // 0: beat k = {4{k}}, 1: random
        int exp_words; // words in the emitted record
        int exp_spk;   // spk_count after the vector
        int exp_drop;  // drop_count after the vector
        int exp_trunc; // trunc_count after the vector
    } vec_t;

    vec_t         vt [6];
    logic [127:0] bt [0:31];
    logic [32:0]  exp_q [$];
    logic [32:0]  got_q [$];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           rdy_mode = 0;
    logic [15:0]  m_seq   = '0;
    logic [31:0]  e_spk   = '0;
    logic [31:0]  e_drop  = '0;
    logic [31:0]  e_trunc = '0;
    logic         prev_vld  = 1'b0;
    logic         prev_rdy  = 1'b0;
    logic         prev_last = 1'b0;
    logic [31:0]  prev_dat  = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Downstream ready: low, high, or random, changed just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_TREADY = 1'b0;
            1:       out_TREADY = 1'b1;
            default: out_TREADY = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: collect handshaken words and check that a stalled word holds.
    always @(negedge clk) begin
        if (rst) begin
            prev_vld = 1'b0;
        end else begin
            if (prev_vld && !prev_rdy) begin
                check("hold_vld", out_TVALID, 1);
                check("hold_dat", out_TDATA, prev_dat);
                check("hold_last", out_TLAST, prev_last);
            end
            if (out_TVALID && out_TREADY) begin
                got_q.push_back({out_TLAST, out_TDATA});
            end
            prev_vld  = out_TVALID;
            prev_rdy  = out_TREADY;
            prev_dat  = out_TDATA;
            prev_last = out_TLAST;
        end
    end

    task automatic fill(input int pattern);
        for (int k = 0; k < 32; k++) begin
            if (pattern == 0) bt[k] = {4{32'(k)}};
            else              bt[k] = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    // Drives n beats (pulse on the first) then 'gap' idle cycles before the next spike may start.
    task automatic drive_spike(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            spk_stream_TVALID = 1'b1;
            spk_stream_pulse  = (i == 0);
            spk_stream_TDATA  = bt[i];
        end
        @(posedge clk); #1;
        spk_stream_TVALID = 1'b0;
        spk_stream_pulse  = 1'b0;
        spk_stream_TDATA  = '0;
        for (int i = 1; i < gap; i++) @(posedge clk);
    endtask

    // Record model for an admitted spike of n driven beats.
    task automatic model_spike(input int n);
        logic [127:0] b;
        exp_q.push_back({1'b0, 8'hA5, 8'(LEN), m_seq});
        for (int k = 0; k < LEN; k++) begin
            b = (k < n) ? bt[k] : 128'd0;
            for (int w = 0; w < 4; w++) begin
                exp_q.push_back({(k == LEN - 1) && (w == 3), b[127 - 32*w -: 32]});
            end
        end
        m_seq++;
        e_spk++;
        if (n < LEN) e_trunc++;
    endtask

    task automatic drain(input string name, output int nw);
        int budget;
        int n;
        budget = 5000;
        while (got_q.size() < exp_q.size() && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        repeat (20) @(negedge clk);
        nw = got_q.size();
        check({name, "_nwords"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_w%0d", name, i), got_q[i], exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_cnt(input string name);
        check({name, "_spk"}, spk_count, e_spk);
        check({name, "_drop"}, drop_count, e_drop);
        check({name, "_trunc"}, trunc_count, e_trunc);
    endtask

    initial begin
        int nw;
        int na, ga, nb;
        logic [15:0] bp_seq0;

        vt[0] = '{19, 1, 0, 77, 1, 0, 0};
        vt[1] = '{ 7, 1, 1, 77, 2, 0, 1};
        vt[2] = '{19, 2, 1, 77, 3, 0, 1};
        vt[3] = '{ 1, 2, 1, 77, 4, 0, 2};
        vt[4] = '{18, 2, 1, 77, 5, 0, 3};
        vt[5] = '{25, 1, 1, 77, 6, 0, 3};

        rst = 1'b1;
        spk_stream_TVALID = 1'b0;
        spk_stream_pulse  = 1'b0;
        spk_stream_TDATA  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_vld", out_TVALID, 0);
        check("rst_dat", out_TDATA, 0);
        check("rst_last", out_TLAST, 0);
        check("rst_spk", spk_count, 0);
        check("rst_drop", drop_count, 0);
        check("rst_trunc", trunc_count, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Vector table: full, truncated, single-beat and over-long spikes
        for (int i = 0; i < 6; i++) begin
            rdy_mode = vt[i].rmode;
            fill(vt[i].pattern);
            model_spike(vt[i].n_beats);
            drive_spike(vt[i].n_beats, 3);
            drain($sformatf("vec%0d", i), nw);
            check($sformatf("vec%0d_len", i), nw, vt[i].exp_words);
            check($sformatf("vec%0d_spk", i), spk_count, vt[i].exp_spk);
            check($sformatf("vec%0d_drop", i), drop_count, vt[i].exp_drop);
            check($sformatf("vec%0d_trunc", i), trunc_count, vt[i].exp_trunc);
        end

        // Pulse in the last padding cycle is dropped; one cycle later it is admitted
        rdy_mode = 1;
        fill(1); model_spike(7); drive_spike(7, 12);
        fill(1); e_drop++;       drive_spike(LEN, 5);
        drain("pad_drop", nw);
        check_cnt("pad_drop");
        fill(1); model_spike(7);   drive_spike(7, 13);
        fill(1); model_spike(LEN); drive_spike(LEN, 2);
        drain("pad_edge", nw);
        check_cnt("pad_edge");

        // Stalled output: three spikes fill the FIFO, the fourth is dropped
        rdy_mode = 0;
        bp_seq0 = m_seq;
        for (int s = 0; s < 4; s++) begin
            fill(1);
            if (s < 3) model_spike(LEN);
            else       e_drop++;
            drive_spike(LEN, 1);
        end
        @(negedge clk);
        check_cnt("bp");
        check("bp_vld", out_TVALID, 1);
        check("bp_hdr", out_TDATA, {8'hA5, 8'(LEN), bp_seq0});
        rdy_mode = 1;
        drain("bp", nw);

        // Randomized pairs of spikes with random ready; second pulse may land in padding
        rdy_mode = 2;
        for (int r = 0; r < 8; r++) begin
            na = $urandom_range(1, LEN + 3);
            ga = $urandom_range(1, 20);
            nb = $urandom_range(1, LEN + 3);
            fill(1); model_spike(na); drive_spike(na, ga);
            fill(1);
            if (na < LEN && ga <= LEN - na) e_drop++;
            else                            model_spike(nb);
            drive_spike(nb, 2);
            drain($sformatf("rnd%0d", r), nw);
            check_cnt($sformatf("rnd%0d", r));
        end

        // Reset in the middle of a record
        rdy_mode = 1;
        fill(1);
        drive_spike(LEN, 1);
        begin
            int b;
            b = 3000;
            while (got_q.size() < 40 && b > 0) begin
                @(negedge clk);
                b--;
            end
        end
        check("mid_w40", got_q.size(), 40);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_vld", out_TVALID, 0);
        check("mid_rst_last", out_TLAST, 0);
        check("mid_rst_spk", spk_count, 0);
        check("mid_rst_drop", drop_count, 0);
        check("mid_rst_trunc", trunc_count, 0);
        got_q.delete();
        exp_q.delete();
        m_seq = '0;
        e_spk = '0; e_drop = '0; e_trunc = '0;

        // Next spike: header latency and seq restart
        fill(1);
        model_spike(LEN);
        fork
            drive_spike(LEN, 2);
            begin
                @(posedge clk);
                @(negedge clk);
                @(negedge clk);
                check("lat_t1_vld", out_TVALID, 0);
                @(negedge clk);
                check("lat_t2_vld", out_TVALID, 1);
                check("lat_hdr_seq0", out_TDATA, 32'hA513_0000);
            end
        join
        drain("post_rst", nw);
        check_cnt("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
